// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: operation encodings and FSM states.
package div_pkg;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_MOD  = 2'b01;
    localparam logic [1:0] DIV_OP_DIVU = 2'b10;
    localparam logic [1:0] DIV_OP_MODU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift {rem,quot} left, trial-subtract divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quot_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quot_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // The shifted partial remainder needs one extra bit; when it is >= divisor the
    // true difference is below the divisor, so the low WIDTH bits of the wrap are exact.
    assign shifted = {rem_i, quot_i[WIDTH-1]};
    assign ge      = (shifted >= {1'b0, divisor_i});
    assign diff    = shifted[WIDTH-1:0] - divisor_i;

    assign rem_o  = ge ? diff : shifted[WIDTH-1:0];
    assign quot_o = {quot_i[WIDTH-2:0], ge};

endmodule

// File: rtl/iter_div_unit.sv
// Iterative radix-2 restoring divider with valid/ready handshakes, tag passthrough and flush.
module iter_div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_src1,
    input  logic [WIDTH-1:0] in_src2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int             CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             q_sign_q, q_sign_d;
    logic             r_sign_q, r_sign_d;
    logic             mod_q, mod_d;

    logic             accept;
    logic             s1_neg, s2_neg;
    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH-1:0] step_rem, step_quot;
    logic [WIDTH-1:0] rem_fix, quot_fix;

    assign in_ready  = resetn & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    assign out_valid = (state_q == DONE) & ~flush;
    assign busy      = (state_q == CALC) | (state_q == DONE);
    assign accept    = in_valid & in_ready & ~flush;

    // Unsigned negation maps the most negative value onto 2^(WIDTH-1) as required.
    assign s1_neg = ~in_op[1] & in_src1[WIDTH-1];
    assign s2_neg = ~in_op[1] & in_src2[WIDTH-1];
    assign mag1   = s1_neg ? -in_src1 : in_src1;
    assign mag2   = s2_neg ? -in_src2 : in_src2;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quot_i    (quot_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quot_o    (step_quot)
    );

    assign quot_fix = q_sign_q ? -step_quot : step_quot;
    assign rem_fix  = r_sign_q ? -step_rem  : step_rem;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        dvs_d    = dvs_q;
        result_d = result_q;
        tag_d    = tag_q;
        q_sign_d = q_sign_q;
        r_sign_d = r_sign_q;
        mod_d    = mod_q;

        case (state_q)
            CALC: begin
                cnt_d  = cnt_q + 1'b1;
                rem_d  = step_rem;
                quot_d = step_quot;
                if (cnt_q == LAST_CNT) begin
                    state_d  = DONE;
                    result_d = mod_q ? rem_fix : quot_fix;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: ;
        endcase

        // Accept is only possible from IDLE or from DONE during the output handshake.
        if (accept) begin
            cnt_d    = '0;
            rem_d    = '0;
            quot_d   = mag1;
            dvs_d    = mag2;
            tag_d    = in_tag;
            q_sign_d = s1_neg ^ s2_neg;
            r_sign_d = s1_neg;
            mod_d    = in_op[0];
            if (in_src2 == '0) begin
                state_d  = DONE;
                result_d = in_op[0] ? in_src1 : '1;
            end else begin
                state_d  = CALC;
            end
        end

        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            dvs_q    <= '0;
            result_q <= '0;
            tag_q    <= '0;
            q_sign_q <= 1'b0;
            r_sign_q <= 1'b0;
            mod_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
            tag_q    <= tag_d;
            q_sign_q <= q_sign_d;
            r_sign_q <= r_sign_d;
            mod_q    <= mod_d;
        end
    end

    assign out_result = result_q;
    assign out_tag    = tag_q;

endmodule

// File: tb/tb_iter_div_unit.sv
// Directed bench for iter_div_unit: vector table plus flush, backpressure and reset sequences.
module tb_iter_div_unit;
    import div_pkg::*;

    localparam int W = 32;
    localparam int T = 5;

    logic         clk = 1'b0;
    logic         resetn;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_op;
    logic [W-1:0] in_src1;
    logic [W-1:0] in_src2;
    logic [T-1:0] in_tag;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic [T-1:0] out_tag;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    iter_div_unit #(.WIDTH(W), .TAG_W(T)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [T-1:0] tag;
        logic [W-1:0] exp;
        int           lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Counts edges until out_valid is seen just after an edge; bounded at 100.
    task automatic wait_valid(output int n);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (out_valid) break;
        end
    endtask

    task automatic drive_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [T-1:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
        in_tag   = tag;
    endtask

    task automatic run_op(input string nm, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [T-1:0] tag,
                          input logic [W-1:0] exp, input int lat);
        int n;
        @(negedge clk);
        drive_op(op, a, b, tag);
        check({nm, " in_ready"}, W'(in_ready), W'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_valid(n);
        check({nm, " latency"}, W'(n), W'(lat));
        check({nm, " result"}, out_result, exp);
        check({nm, " tag"}, W'(out_tag), W'(tag));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({nm, " idle after handshake"}, W'(busy), W'(0));
        $display("op %s a=0x%08h b=0x%08h tag=%0d -> 0x%08h after %0d edges", nm, a, b, tag, out_result, n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  saw_valid;

        vecs[0]  = '{DIV_OP_DIVU, 32'd100,        32'd7,          5'd3,  32'd14,         32};
        vecs[1]  = '{DIV_OP_MODU, 32'd100,        32'd7,          5'd4,  32'd2,          32};
        vecs[2]  = '{DIV_OP_DIV,  32'hFFFFFFF9,   32'd2,          5'd5,  32'hFFFFFFFD,   32};
        vecs[3]  = '{DIV_OP_MOD,  32'hFFFFFFF9,   32'd2,          5'd6,  32'hFFFFFFFF,   32};
        vecs[4]  = '{DIV_OP_DIV,  32'd7,          32'hFFFFFFFE,   5'd7,  32'hFFFFFFFD,   32};
        vecs[5]  = '{DIV_OP_MOD,  32'd7,          32'hFFFFFFFE,   5'd8,  32'd1,          32};
        vecs[6]  = '{DIV_OP_DIV,  32'h80000000,   32'hFFFFFFFF,   5'd9,  32'h80000000,   32};
        vecs[7]  = '{DIV_OP_MOD,  32'h80000000,   32'hFFFFFFFF,   5'd10, 32'd0,          32};
        vecs[8]  = '{DIV_OP_DIVU, 32'hFFFFFFFF,   32'd1,          5'd11, 32'hFFFFFFFF,   32};
        vecs[9]  = '{DIV_OP_DIVU, 32'd5,          32'd0,          5'd12, 32'hFFFFFFFF,   1};
        vecs[10] = '{DIV_OP_MODU, 32'd5,          32'd0,          5'd13, 32'd5,          1};
        vecs[11] = '{DIV_OP_MOD,  32'hFFFFFFFB,   32'd0,          5'd14, 32'hFFFFFFFB,   1};
        vecs[12] = '{DIV_OP_DIV,  32'hFFFFFFFB,   32'd0,          5'd15, 32'hFFFFFFFF,   1};
        vecs[13] = '{DIV_OP_DIVU, 32'hDEADBEEF,   32'h10,         5'd16, 32'h0DEADBEE,   32};
        vecs[14] = '{DIV_OP_MODU, 32'hDEADBEEF,   32'h10,         5'd17, 32'hF,          32};
        vecs[15] = '{DIV_OP_MOD,  32'hFFFFFF9C,   32'd7,          5'd31, 32'hFFFFFFFE,   32};

        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_src1   = '0;
        in_src2   = '0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", W'(in_ready), W'(0));
        check("reset out_valid", W'(out_valid), W'(0));
        check("reset busy", W'(busy), W'(0));
        check("reset out_result", out_result, '0);
        check("reset out_tag", W'(out_tag), W'(0));
        resetn = 1'b1;
        @(negedge clk);
        check("post-reset in_ready", W'(in_ready), W'(1));

        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].tag, vecs[i].exp, vecs[i].lat);
        end

        // Flush on CALC cycle 10: no result ever appears.
        @(negedge clk);
        drive_op(DIV_OP_DIVU, 32'd1000, 32'd3, 5'd2);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush calc in_ready", W'(in_ready), W'(1));
        check("flush calc busy", W'(busy), W'(0));
        saw_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        check("flush calc no out_valid", W'(saw_valid), W'(0));
        $display("flush in CALC cycle 10: out_valid seen=%0d", saw_valid);
        run_op("divu 9/3 after flush", DIV_OP_DIVU, 32'd9, 32'd3, 5'd21, 32'd3, 32);

        // Flush during DONE with out_ready high: result dropped, no handshake.
        @(negedge clk);
        drive_op(DIV_OP_DIVU, 32'd50, 32'd5, 5'd22);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_valid(n);
        check("flush done latency", W'(n), W'(32));
        @(negedge clk);
        flush     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("flush done out_valid forced low", W'(out_valid), W'(0));
        @(posedge clk);
        #1 flush = 1'b0;
        out_ready = 1'b0;
        check("flush done busy", W'(busy), W'(0));
        check("flush done in_ready", W'(in_ready), W'(1));
        check("flush done out_valid after", W'(out_valid), W'(0));
        $display("flush in DONE: busy=%0d in_ready=%0d", busy, in_ready);

        // Backpressure: hold result for 5 cycles, then handshake and accept on one edge.
        @(negedge clk);
        drive_op(DIV_OP_DIVU, 32'd77, 32'd7, 5'd9);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_valid(n);
        check("bp latency", W'(n), W'(32));
        @(negedge clk);
        drive_op(DIV_OP_DIVU, 32'd20, 32'd4, 5'd12);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp hold%0d out_valid", c), W'(out_valid), W'(1));
            check($sformatf("bp hold%0d result", c), out_result, 32'd11);
            check($sformatf("bp hold%0d tag", c), W'(out_tag), W'(9));
            check($sformatf("bp hold%0d in_ready", c), W'(in_ready), W'(0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", W'(in_ready), W'(1));
        @(posedge clk);
        #1 out_ready = 1'b0;
        in_valid = 1'b0;
        check("bp back-to-back busy", W'(busy), W'(1));
        check("bp back-to-back out_valid", W'(out_valid), W'(0));
        wait_valid(n);
        check("bp b2b latency", W'(n), W'(32));
        check("bp b2b result", out_result, 32'd5);
        check("bp b2b tag", W'(out_tag), W'(12));
        $display("backpressure then divu 20/4 -> 0x%08h tag=%0d after %0d edges", out_result, out_tag, n);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        drive_op(DIV_OP_DIVU, 32'd123, 32'd4, 5'd7);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        check("async reset busy", W'(busy), W'(0));
        check("async reset out_valid", W'(out_valid), W'(0));
        check("async reset in_ready", W'(in_ready), W'(0));
        check("async reset out_result", out_result, '0);
        check("async reset out_tag", W'(out_tag), W'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("after reset in_ready", W'(in_ready), W'(1));
        check("after reset busy", W'(busy), W'(0));
        saw_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        check("after reset no out_valid", W'(saw_valid), W'(0));
        $display("async reset mid-CALC: in_ready=%0d busy=%0d", in_ready, busy);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
